// File: rtl/fifo_arb_pkg.sv
// Shared types and sizing helpers for the FIFO write arbiter.
// Pure compile-time content: no logic, no latency.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r++;
    end
    return r;
  endfunction

  // Index width for n requesters; never narrower than one bit.
  function automatic int src_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// Round-robin picker: first set request searching upward from last+1, wrapping.
// Purely combinational, zero latency; no backpressure of its own.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          vld,
  output logic [IW-1:0] idx
);

  // Scan from the farthest offset down so the nearest hit is written last and wins.
  always_comb begin
    vld = 1'b0;
    idx = '0;
    for (int i = N; i >= 1; i--) begin
      if (req[(int'(last) + i) % N]) begin
        vld = 1'b1;
        idx = IW'((int'(last) + i) % N);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin burst arbiter sharing one FIFO write port; grant one cycle after valid, 1-cycle bubble between bursts.
// Full FIFO drops ready and freezes the burst. FIFO_ARB_SRCID_EN prepends the owner index to fifo_din_o.
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 8
) (
  input  logic                          clk_i,
  input  logic                          resetz_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ-1:0]            req_last_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic                          fifo_full_i,
  output logic                          fifo_wr_o,
`ifdef FIFO_ARB_SRCID_EN
  output logic [DATA_WIDTH+src_w(NUM_REQ)-1:0] fifo_din_o,
`else
  output logic [DATA_WIDTH-1:0]         fifo_din_o,
`endif
  output logic [NUM_REQ-1:0]            grant_o,
  output logic                          busy_o
);

  localparam int SRC_W = src_w(NUM_REQ);
  localparam int CNT_W = clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

  arb_state_e           state_q, state_d;
  logic [SRC_W-1:0]     owner_q, owner_d;
  logic [SRC_W-1:0]     last_q, last_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 pick_vld;
  logic [SRC_W-1:0]     pick_idx;
  logic                 xfer;
  logic [DATA_WIDTH-1:0] owner_dat;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (SRC_W)
  ) u_pick (
    .req  (req_valid_i),
    .last (last_q),
    .vld  (pick_vld),
    .idx  (pick_idx)
  );

  assign owner_dat = req_data_i[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];

  // last_q resets to the top index so requester 0 wins the first arbitration.
  always_ff @(posedge clk_i or negedge resetz_i) begin
    if (!resetz_i) begin
      state_q <= IDLE;
      owner_q <= '0;
      cnt_q   <= '0;
      last_q  <= SRC_W'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    req_ready_o = '0;
    grant_o     = '0;
    fifo_wr_o   = 1'b0;
    fifo_din_o  = '0;
    busy_o      = 1'b0;
    xfer        = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = BURST;
          owner_d = pick_idx;
          cnt_d   = '0;
        end
      end
      BURST: begin
        busy_o               = 1'b1;
        grant_o[owner_q]     = 1'b1;
        req_ready_o[owner_q] = !fifo_full_i;
        xfer                 = req_valid_i[owner_q] && !fifo_full_i;
        if (xfer) begin
          fifo_wr_o = 1'b1;
`ifdef FIFO_ARB_SRCID_EN
          fifo_din_o = {owner_q, owner_dat};
`else
          fifo_din_o = owner_dat;
`endif
          cnt_d = cnt_q + 1'b1;
          // A burst cut at the cap re-arbitrates with no carried-over priority.
          if (req_last_i[owner_q] || cnt_q == CNT_MAX) begin
            state_d = IDLE;
            last_d  = owner_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Randomized bench for fifo_wr_arb against a transaction-level queue model.
module tb_fifo_wr_arb;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int MB = 8;
  localparam int SW = 2;
`ifdef FIFO_ARB_SRCID_EN
  localparam int OW = DW + SW;
`else
  localparam int OW = DW;
`endif

  typedef struct {
    logic [DW-1:0] dat;
    logic          last;
  } beat_t;

  logic             clk_i = 1'b0;
  logic             resetz_i;
  logic [NR-1:0]    req_valid_i;
  logic [NR-1:0]    req_last_i;
  logic [NR*DW-1:0] req_data_i;
  logic [NR-1:0]    req_ready_o;
  logic             fifo_full_i;
  logic             fifo_wr_o;
  logic [OW-1:0]    fifo_din_o;
  logic [NR-1:0]    grant_o;
  logic             busy_o;

  fifo_wr_arb #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB)
  ) dut (
    .clk_i       (clk_i),
    .resetz_i    (resetz_i),
    .req_valid_i (req_valid_i),
    .req_last_i  (req_last_i),
    .req_data_i  (req_data_i),
    .req_ready_o (req_ready_o),
    .fifo_full_i (fifo_full_i),
    .fifo_wr_o   (fifo_wr_o),
    .fifo_din_o  (fifo_din_o),
    .grant_o     (grant_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;
  int n_dut_wr = 0;
  beat_t q [NR][$];
  logic [NR-1:0] pres;
  logic [NR-1:0] hs;
  int   vld_pct = 100;
  int   full_pct = 0;
  logic full_force = 1'b0;
  // Model: who owns the port, beats moved in this grant, who was served last.
  int   m_busy, m_owner, m_beats, m_last;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pending();
    int s;
    s = 0;
    for (int k = 0; k < NR; k++) s += q[k].size();
    return s;
  endfunction

  task automatic drive();
    for (int k = 0; k < NR; k++) begin
      if (!pres[k] && q[k].size() > 0 && int'($urandom_range(0, 99)) < vld_pct) pres[k] = 1'b1;
      req_valid_i[k]         = pres[k];
      req_last_i[k]          = pres[k] ? q[k][0].last : 1'b0;
      req_data_i[k*DW +: DW] = pres[k] ? q[k][0].dat : '0;
    end
    fifo_full_i = full_force || (int'($urandom_range(0, 99)) < full_pct);
  endtask

  task automatic push(input int k, input int len, input logic [DW-1:0] base, input bit with_last);
    for (int i = 0; i < len; i++) begin
      beat_t b;
      b.dat  = base + DW'(i);
      b.last = with_last && (i == len - 1);
      q[k].push_back(b);
    end
  endtask

  task automatic cycle();
    logic [NR-1:0] e_rdy, e_gnt;
    logic          e_wr, e_busy, found;
    logic [OW-1:0] e_din;
    @(negedge clk_i);
    e_rdy = '0; e_gnt = '0; e_wr = 1'b0; e_din = '0; hs = '0; found = 1'b0;
    e_busy = (m_busy != 0);
    if (m_busy != 0) begin
      e_gnt[m_owner] = 1'b1;
      if (!fifo_full_i) e_rdy[m_owner] = 1'b1;
      if (pres[m_owner] && !fifo_full_i) begin
        e_wr = 1'b1;
        hs[m_owner] = 1'b1;
        m_beats++;
`ifdef FIFO_ARB_SRCID_EN
        e_din = {SW'(m_owner), q[m_owner][0].dat};
`else
        e_din = q[m_owner][0].dat;
`endif
        if (q[m_owner][0].last || m_beats == MB) begin
          m_busy = 0;
          m_last = m_owner;
        end
      end
    end else begin
      for (int i = 1; i <= NR; i++) begin
        int c = (m_last + i) % NR;
        if (!found && pres[c]) begin
          found = 1'b1; m_busy = 1; m_owner = c; m_beats = 0;
        end
      end
    end
    if (fifo_wr_o === 1'b1) n_dut_wr++;
    chk("wr",    64'(fifo_wr_o),   64'(e_wr));
    chk("din",   64'(fifo_din_o),  64'(e_din));
    chk("ready", 64'(req_ready_o), 64'(e_rdy));
    chk("grant", 64'(grant_o),     64'(e_gnt));
    chk("busy",  64'(busy_o),      64'(e_busy));
    @(posedge clk_i);
    #1;
    for (int k = 0; k < NR; k++) begin
      if (hs[k]) begin
        void'(q[k].pop_front());
        pres[k] = 1'b0;
      end
    end
    drive();
  endtask

  task automatic run_drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((pending() != 0 || m_busy != 0) && n < budget) begin
      cycle();
      n++;
    end
    chk(tag, {31'b0, busy_o, 32'(pending())}, 64'd0);
  endtask

  task automatic wait_beats(input string tag, input int nb);
    int n;
    n = 0;
    while (!(m_busy != 0 && m_beats == nb) && n < 40) begin
      cycle();
      n++;
    end
    chk(tag, 64'(busy_o), 64'd1);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_wr"},    64'(fifo_wr_o),   64'd0);
    chk({tag, "_din"},   64'(fifo_din_o),  64'd0);
    chk({tag, "_ready"}, 64'(req_ready_o), 64'd0);
    chk({tag, "_grant"}, 64'(grant_o),     64'd0);
    chk({tag, "_busy"},  64'(busy_o),      64'd0);
  endtask

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_beats = 0; m_last = NR - 1;
    for (int k = 0; k < NR; k++) q[k].delete();
    pres = '0;
    hs   = '0;
  endtask

  initial begin
    int w0;
    resetz_i = 1'b0;
    req_valid_i = '0; req_last_i = '0; req_data_i = '0; fifo_full_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    chk_idle_outputs("reset");
    resetz_i = 1'b1;

    // Single 3-beat burst from requester 0.
    w0 = n_dut_wr;
    push(0, 3, 32'hA0, 1'b1);
    drive();
    run_drain("a_drain", 50);
    chk("a_writes", 64'(n_dut_wr - w0), 64'd3);

    // Everyone with single-beat bursts: strict rotation with bubbles.
    w0 = n_dut_wr;
    for (int k = 0; k < NR; k++) push(k, 1, 32'h10 + 32'(k), 1'b1);
    for (int k = 0; k < NR; k++) push(k, 1, 32'h20 + 32'(k), 1'b1);
    drive();
    run_drain("b_drain", 100);
    chk("b_writes", 64'(n_dut_wr - w0), 64'd8);

    // Long lastless stream from requester 2 is cut at MAX_BURST; requester 3 slips in.
    w0 = n_dut_wr;
    push(2, 20, 32'h200, 1'b0);
    push(2, 4, 32'h214, 1'b1);
    push(3, 1, 32'h300, 1'b1);
    drive();
    run_drain("c_drain", 100);
    chk("c_writes", 64'(n_dut_wr - w0), 64'd25);

    // FIFO full for 5 cycles in the middle of a burst.
    w0 = n_dut_wr;
    push(1, 6, 32'h100, 1'b1);
    drive();
    wait_beats("d_reach", 2);
    full_force  = 1'b1;
    fifo_full_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) full_force = 1'b0;
      cycle();
    end
    chk("d_stall", 64'(n_dut_wr - w0), 64'd2);
    run_drain("d_drain", 50);
    chk("d_writes", 64'(n_dut_wr - w0), 64'd6);

    // Random traffic with valid gaps and FIFO backpressure.
    vld_pct  = 60;
    full_pct = 25;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0)
        push(int'($urandom_range(0, NR - 1)), int'($urandom_range(1, 12)), $urandom, 1'b1);
      cycle();
    end
    full_pct = 0;
    run_drain("e_drain", 1500);

    // Asynchronous reset during beat 2 of a burst.
    vld_pct = 100;
    push(2, 4, 32'h2A0, 1'b1);
    drive();
    wait_beats("f_reach", 1);
    #2 resetz_i = 1'b0;
    #1 chk_idle_outputs("f_async");
    model_reset();
    drive();
    cycle();
    cycle();
    resetz_i = 1'b1;
    push(3, 1, 32'h3F0, 1'b1);
    push(1, 1, 32'h1F0, 1'b1);
    push(0, 1, 32'h0F0, 1'b1);
    drive();
    cycle();
    chk("f_first_grant", 64'(grant_o), 64'd1);
    run_drain("f_drain", 50);

`ifdef FIFO_ARB_SRCID_EN
    push(3, 1, 32'h55, 1'b1);
    drive();
    run_drain("g_drain", 20);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
